// File: rtl/mcp3202_pkg.sv
// Shared types and constants for the MCP3202 responder: FSM state, debug view, diff clamp.
package mcp3202_pkg;

   localparam int   DATA_W    = 12;
   localparam int   CFG_BITS  = 3;
   localparam logic START_BIT = 1'b1;

   typedef enum logic [2:0] {
      IDLE,
      CFG,
      NULLB,
      MSB_DATA,
      LSB_DATA,
      DONE
   } state_t;

   // Debug view for checker binding; vector bit order is {cs, spi_clk, mosi}.
   typedef struct packed {
      state_t     state;
      logic [2:0] lvl;
      logic [2:0] rise;
      logic [2:0] fall;
   } dbg_t;

   // Pseudo-differential result: a negative difference reads as zero.
   function automatic logic [DATA_W-1:0] diff_clamp(input logic [DATA_W-1:0] a,
                                                    input logic [DATA_W-1:0] b);
      logic [DATA_W:0] d;
      d = {1'b0, a} - {1'b0, b};
      return d[DATA_W] ? '0 : d[DATA_W-1:0];
   endfunction

endpackage

// File: rtl/mcp3202_responder_spi_in_sync.sv
// Synchroniser chain plus compare flop for one asynchronous SPI pin; emits level and edge pulses.
module spi_in_sync
   import mcp3202_pkg::*;
#(
   parameter int   SYNC_STAGES = 2,
   parameter logic RST_VAL     = 1'b0
) (
   input  logic i_clk,
   input  logic i_rst,
   input  logic i_d,
   output logic o_level,
   output logic o_rise,
   output logic o_fall
);

   logic [SYNC_STAGES-1:0] r_sync;
   logic                   r_prev;

   always_ff @(posedge i_clk) begin
      if (i_rst) begin
         r_sync <= {SYNC_STAGES{RST_VAL}};
         r_prev <= RST_VAL;
      end else begin
         r_sync <= {r_sync[SYNC_STAGES-2:0], i_d};
         r_prev <= r_sync[SYNC_STAGES-1];
      end
   end

   assign o_level = r_sync[SYNC_STAGES-1];
   assign o_rise  = r_sync[SYNC_STAGES-1] & ~r_prev;
   assign o_fall  = ~r_sync[SYNC_STAGES-1] & r_prev;

endmodule

// File: rtl/mcp3202_responder.sv
// MCP3202 SPI peripheral model: decodes start/SGL/ODD/MSBF and shifts back null + 12 data bits.
// Optional RESPONDER_STATS_EN adds frame and abort counters.
module mcp3202_responder #(
   parameter int DATA_W      = 12,
   parameter int SYNC_STAGES = 2
) (
   input  logic                    i_clk,
   input  logic                    i_rst,
   input  logic                    i_cs,
   input  logic                    i_spi_clk,
   input  logic                    i_mosi,
   input  logic [DATA_W-1:0]       i_ch0_data,
   input  logic [DATA_W-1:0]       i_ch1_data,
   output logic                    o_miso,
   output logic                    o_miso_oe,
   output logic                    o_cfg_valid,
   output logic                    o_cfg_sgl,
   output logic                    o_cfg_odd,
   output logic                    o_cfg_msbf,
   output logic                    o_conv_done,
`ifdef RESPONDER_STATS_EN
   output logic [15:0]             o_frame_count,
   output logic [15:0]             o_abort_count,
`endif
   output mcp3202_pkg::dbg_t       o_dbg
);
   import mcp3202_pkg::*;

   localparam logic [3:0] LAST_BIT = 4'(DATA_W);
   localparam logic [3:0] TOP_BIT  = 4'(DATA_W - 1);

   logic w_cs_lvl, w_cs_rise, w_cs_fall;
   logic w_sck_lvl, w_sck_rise, w_sck_fall;
   logic w_mosi_lvl, w_mosi_rise, w_mosi_fall;

   spi_in_sync #(.SYNC_STAGES(SYNC_STAGES), .RST_VAL(1'b1)) u_sync_cs (
      .i_clk(i_clk), .i_rst(i_rst), .i_d(i_cs),
      .o_level(w_cs_lvl), .o_rise(w_cs_rise), .o_fall(w_cs_fall));

   spi_in_sync #(.SYNC_STAGES(SYNC_STAGES), .RST_VAL(1'b0)) u_sync_sck (
      .i_clk(i_clk), .i_rst(i_rst), .i_d(i_spi_clk),
      .o_level(w_sck_lvl), .o_rise(w_sck_rise), .o_fall(w_sck_fall));

   spi_in_sync #(.SYNC_STAGES(SYNC_STAGES), .RST_VAL(1'b0)) u_sync_mosi (
      .i_clk(i_clk), .i_rst(i_rst), .i_d(i_mosi),
      .o_level(w_mosi_lvl), .o_rise(w_mosi_rise), .o_fall(w_mosi_fall));

   state_t            r_state, w_state;
   logic [1:0]        r_cfg_cnt, w_cfg_cnt;
   logic [3:0]        r_bit_cnt, w_bit_cnt;
   logic [DATA_W-1:0] r_sample, w_sample, w_sel;
   logic              r_cap_sgl, w_cap_sgl, r_cap_odd, w_cap_odd;
   logic              r_sgl, w_sgl, r_odd, w_odd, r_msbf, w_msbf;
   logic              r_miso, w_miso, r_miso_oe, w_miso_oe;
   logic              r_cfg_valid, w_cfg_valid, r_conv_done, w_conv_done;
   logic              w_abort;
   logic [3:0]        w_msb_idx;

   // Sample select uses SGL/ODD captured on the two preceding rises.
   always_comb begin
      w_sel = i_ch0_data;
      if (r_cap_sgl)
         w_sel = r_cap_odd ? i_ch1_data : i_ch0_data;
      else
         w_sel = r_cap_odd ? diff_clamp(i_ch1_data, i_ch0_data)
                           : diff_clamp(i_ch0_data, i_ch1_data);
   end

   assign w_msb_idx = TOP_BIT - r_bit_cnt;

   always_comb begin
      w_state     = r_state;
      w_cfg_cnt   = r_cfg_cnt;
      w_bit_cnt   = r_bit_cnt;
      w_sample    = r_sample;
      w_cap_sgl   = r_cap_sgl;
      w_cap_odd   = r_cap_odd;
      w_sgl       = r_sgl;
      w_odd       = r_odd;
      w_msbf      = r_msbf;
      w_miso      = r_miso;
      w_miso_oe   = r_miso_oe;
      w_cfg_valid = 1'b0;
      w_conv_done = 1'b0;
      w_abort     = 1'b0;

      // Deselect wins over any coincident serial-clock edge.
      if (w_cs_rise) begin
         w_state   = IDLE;
         w_miso    = 1'b0;
         w_miso_oe = 1'b0;
         w_cfg_cnt = '0;
         w_bit_cnt = '0;
         w_abort   = (r_state != IDLE) && (r_state != DONE);
      end else if (w_cs_fall) begin
         w_state   = IDLE;
         w_miso    = 1'b0;
         w_miso_oe = 1'b1;
         w_cfg_cnt = '0;
         w_bit_cnt = '0;
      end else begin
         case (r_state)
            IDLE: begin
               if (w_sck_rise && !w_cs_lvl && (w_mosi_lvl == START_BIT)) begin
                  w_state   = CFG;
                  w_cfg_cnt = '0;
               end
            end
            CFG: begin
               if (w_sck_rise) begin
                  w_cfg_cnt = r_cfg_cnt + 2'd1;
                  if (r_cfg_cnt == 2'd0)
                     w_cap_sgl = w_mosi_lvl;
                  else if (r_cfg_cnt == 2'd1)
                     w_cap_odd = w_mosi_lvl;
                  else if (r_cfg_cnt == 2'(CFG_BITS - 1)) begin
                     w_sgl       = r_cap_sgl;
                     w_odd       = r_cap_odd;
                     w_msbf      = w_mosi_lvl;
                     w_cfg_valid = 1'b1;
                     w_sample    = w_sel;
                     w_state     = NULLB;
                  end
               end
            end
            NULLB: begin
               if (w_sck_fall) begin
                  w_miso    = 1'b0;
                  w_bit_cnt = '0;
                  w_state   = MSB_DATA;
               end
            end
            MSB_DATA: begin
               if (w_sck_fall) begin
                  if (r_bit_cnt != LAST_BIT) begin
                     w_miso    = r_sample[w_msb_idx];
                     w_bit_cnt = r_bit_cnt + 4'd1;
                  end else if (r_msbf) begin
                     w_miso      = 1'b0;
                     w_conv_done = 1'b1;
                     w_state     = DONE;
                  end else begin
                     // B0 was already sent; the LSB-first pass resumes at B1.
                     w_miso    = r_sample[1];
                     w_bit_cnt = 4'd2;
                     w_state   = LSB_DATA;
                  end
               end
            end
            LSB_DATA: begin
               if (w_sck_fall) begin
                  if (r_bit_cnt != LAST_BIT) begin
                     w_miso    = r_sample[r_bit_cnt];
                     w_bit_cnt = r_bit_cnt + 4'd1;
                  end else begin
                     w_miso      = 1'b0;
                     w_conv_done = 1'b1;
                     w_state     = DONE;
                  end
               end
            end
            DONE:    w_miso = 1'b0;
            default: w_state = IDLE;
         endcase
      end
   end

   always_ff @(posedge i_clk) begin
      if (i_rst) begin
         r_state     <= IDLE;
         r_cfg_cnt   <= '0;
         r_bit_cnt   <= '0;
         r_sample    <= '0;
         r_cap_sgl   <= 1'b0;
         r_cap_odd   <= 1'b0;
         r_sgl       <= 1'b0;
         r_odd       <= 1'b0;
         r_msbf      <= 1'b0;
         r_miso      <= 1'b0;
         r_miso_oe   <= 1'b0;
         r_cfg_valid <= 1'b0;
         r_conv_done <= 1'b0;
      end else begin
         r_state     <= w_state;
         r_cfg_cnt   <= w_cfg_cnt;
         r_bit_cnt   <= w_bit_cnt;
         r_sample    <= w_sample;
         r_cap_sgl   <= w_cap_sgl;
         r_cap_odd   <= w_cap_odd;
         r_sgl       <= w_sgl;
         r_odd       <= w_odd;
         r_msbf      <= w_msbf;
         r_miso      <= w_miso;
         r_miso_oe   <= w_miso_oe;
         r_cfg_valid <= w_cfg_valid;
         r_conv_done <= w_conv_done;
      end
   end

`ifdef RESPONDER_STATS_EN
   logic [15:0] r_frame_count, r_abort_count;

   always_ff @(posedge i_clk) begin
      if (i_rst) begin
         r_frame_count <= '0;
         r_abort_count <= '0;
      end else begin
         if (w_conv_done) r_frame_count <= r_frame_count + 16'd1;
         if (w_abort)     r_abort_count <= r_abort_count + 16'd1;
      end
   end

   assign o_frame_count = r_frame_count;
   assign o_abort_count = r_abort_count;
`endif

   assign o_miso      = r_miso;
   assign o_miso_oe   = r_miso_oe;
   assign o_cfg_valid = r_cfg_valid;
   assign o_cfg_sgl   = r_sgl;
   assign o_cfg_odd   = r_odd;
   assign o_cfg_msbf  = r_msbf;
   assign o_conv_done = r_conv_done;

   assign o_dbg.state = r_state;
   assign o_dbg.lvl   = {w_cs_lvl, w_sck_lvl, w_mosi_lvl};
   assign o_dbg.rise  = {w_cs_rise, w_sck_rise, w_mosi_rise};
   assign o_dbg.fall  = {w_cs_fall, w_sck_fall, w_mosi_fall};

endmodule

// File: tb/tb_mcp3202_responder.sv
// Directed bench for mcp3202_responder: plays the SPI master and checks frames against hand values.
module tb_mcp3202_responder;
   import mcp3202_pkg::*;

   localparam int HALF = 8;  // spi_clk half period in system clocks

   logic        clk = 1'b0;
   logic        rst, cs, spi_clk, mosi;
   logic [11:0] ch0, ch1;
   logic        miso, miso_oe, cfg_valid, cfg_sgl, cfg_odd, cfg_msbf, conv_done;
   dbg_t        dbg;
`ifdef RESPONDER_STATS_EN
   logic [15:0] frame_count, abort_count;
`endif

   mcp3202_responder #(.DATA_W(12), .SYNC_STAGES(2)) dut (
      .i_clk(clk), .i_rst(rst), .i_cs(cs), .i_spi_clk(spi_clk), .i_mosi(mosi),
      .i_ch0_data(ch0), .i_ch1_data(ch1),
      .o_miso(miso), .o_miso_oe(miso_oe), .o_cfg_valid(cfg_valid),
      .o_cfg_sgl(cfg_sgl), .o_cfg_odd(cfg_odd), .o_cfg_msbf(cfg_msbf),
      .o_conv_done(conv_done),
`ifdef RESPONDER_STATS_EN
      .o_frame_count(frame_count), .o_abort_count(abort_count),
`endif
      .o_dbg(dbg));

   // ---------------- clock / watchdog ----------------
   always #5 clk = ~clk;

   initial begin
      #2ms;
      $display("FAIL watchdog: simulation time limit reached");
      $fatal(1, "watchdog");
   end

   // ---------------- scoreboard counters ----------------
   int          n_checks = 0;
   int          n_fails  = 0;
   int          fall_cnt = 0;
   int          done_cnt = 0, done_fall = 0;
   int          cfgv_cnt = 0, cfgv_fall = 0;
   int          chg_rise = 0;
   logic [11:0] chg_val  = '0;

   always @(negedge clk) begin
      if (conv_done) begin
         done_cnt++;
         done_fall = fall_cnt;
      end
      if (cfg_valid) begin
         cfgv_cnt++;
         cfgv_fall = fall_cnt;
      end
   end

   task automatic check_eq(input string tag, input logic [31:0] got, input logic [31:0] exp);
      n_checks++;
      if (got !== exp) begin
         n_fails++;
         $display("FAIL %s: got %0h expected %0h", tag, got, exp);
      end
   endtask

   task automatic wait_clks(input int n);
      repeat (n) @(posedge clk);
      #1;
   endtask

   // ---------------- driver ----------------
   // Plays lz leading zeros then nclk clocks starting with the start bit; miso is sampled at each rise.
   task automatic run_frame(input logic sgl, input logic odd, input logic msbf,
                            input int lz, input int nclk, input logic [11:0] exp,
                            input string tag, input bit full);
      int          k, d0, c0;
      logic [11:0] mv, lv;
      logic        pre, oe0;
      d0 = done_cnt; c0 = cfgv_cnt;
      mv = '0; lv = '0; pre = 1'b0; oe0 = 1'b0;
      fall_cnt = 0;
      cs = 1'b0;
      wait_clks(2 * HALF);
      for (int i = 0; i < lz + nclk; i++) begin
         k = i - lz + 1;
         if (k <= 0)      mosi = 1'b0;
         else if (k == 1) mosi = 1'b1;
         else if (k == 2) mosi = sgl;
         else if (k == 3) mosi = odd;
         else if (k == 4) mosi = msbf;
         else             mosi = 1'b0;
         wait_clks(HALF);
         if (chg_rise > 0 && k == chg_rise) ch0 = chg_val;
         if (k == 1) oe0 = miso_oe;
         if (k >= 1 && k <= 5)   pre = pre | miso;
         if (k >= 6 && k <= 17)  mv[17-k] = miso;
         if (k >= 18 && k <= 28) lv[k-17] = miso;
         spi_clk = 1'b1;
         wait_clks(HALF);
         spi_clk = 1'b0;
         if (k >= 1) fall_cnt++;
      end
      wait_clks(2 * HALF);
      if (full) begin
         check_eq({tag, "_oe_sel"}, 32'(oe0), 32'd1);
         check_eq({tag, "_lead_null"}, 32'(pre), 32'd0);
         check_eq({tag, "_msb_data"}, 32'(mv), 32'(exp));
         if (!msbf) check_eq({tag, "_lsb_data"}, 32'(lv[11:1]), 32'(exp[11:1]));
         check_eq({tag, "_done_cnt"}, 32'(done_cnt - d0), 32'd1);
         check_eq({tag, "_done_fall"}, 32'(done_fall), 32'(nclk));
         check_eq({tag, "_cfgv_cnt"}, 32'(cfgv_cnt - c0), 32'd1);
         check_eq({tag, "_cfgv_fall"}, 32'(cfgv_fall), 32'd3);
         check_eq({tag, "_cfg_bits"}, {29'd0, cfg_sgl, cfg_odd, cfg_msbf}, {29'd0, sgl, odd, msbf});
         check_eq({tag, "_done_miso"}, 32'(miso), 32'd0);
         check_eq({tag, "_done_oe"}, 32'(miso_oe), 32'd1);
         check_eq({tag, "_done_state"}, 32'(dbg.state), 32'(DONE));
         cs = 1'b1;
         wait_clks(3);
         check_eq({tag, "_release_oe"}, 32'(miso_oe), 32'd0);
         wait_clks(HALF);
      end
   endtask

   // ---------------- stimulus ----------------
   int d_abort;

   initial begin
      rst = 1'b1; cs = 1'b1; spi_clk = 1'b0; mosi = 1'b0;
      ch0 = '0; ch1 = '0;
      wait_clks(4);
      rst = 1'b0;
      wait_clks(2);
      check_eq("rst_miso", 32'(miso), 32'd0);
      check_eq("rst_oe", 32'(miso_oe), 32'd0);
      check_eq("rst_cfg_valid", 32'(cfg_valid), 32'd0);
      check_eq("rst_cfg_bits", {29'd0, cfg_sgl, cfg_odd, cfg_msbf}, 32'd0);
      check_eq("rst_conv_done", 32'(conv_done), 32'd0);
      check_eq("rst_state", 32'(dbg.state), 32'(IDLE));

      // Abort after B11..B6 have been presented.
      ch0 = 12'hABC; ch1 = 12'h111;
      d_abort = done_cnt;
      run_frame(1'b1, 1'b0, 1'b1, 0, 10, 12'h000, "abort", 1'b0);
      check_eq("abort_oe_before", 32'(miso_oe), 32'd1);
      cs = 1'b1;
      wait_clks(3);
      check_eq("abort_oe", 32'(miso_oe), 32'd0);
      check_eq("abort_miso", 32'(miso), 32'd0);
      check_eq("abort_state", 32'(dbg.state), 32'(IDLE));
      wait_clks(2 * HALF);
      check_eq("abort_no_done", 32'(done_cnt - d_abort), 32'd0);
`ifdef RESPONDER_STATS_EN
      check_eq("abort_abort_count", 32'(abort_count), 32'd1);
      check_eq("abort_frame_count", 32'(frame_count), 32'd0);
`endif

      ch0 = 12'hA5C; ch1 = 12'h3C3;
      run_frame(1'b1, 1'b0, 1'b1, 0, 17, 12'hA5C, "se_ch0", 1'b1);

      ch0 = 12'h5A5; ch1 = 12'h801;
      run_frame(1'b1, 1'b1, 1'b0, 0, 28, 12'h801, "lsbf_ch1", 1'b1);

      ch0 = 12'h100; ch1 = 12'h300;
      run_frame(1'b0, 1'b0, 1'b1, 0, 17, 12'h000, "diff_neg", 1'b1);
      run_frame(1'b0, 1'b1, 1'b1, 0, 17, 12'h200, "diff_pos", 1'b1);

      ch0 = 12'hFFF; ch1 = 12'h000;
      run_frame(1'b1, 1'b0, 1'b1, 2, 17, 12'hFFF, "lead0", 1'b1);

      // Channel data changes mid-frame; the latched sample must be returned.
      ch0 = 12'h123; chg_rise = 8; chg_val = 12'hFFF;
      run_frame(1'b1, 1'b0, 1'b1, 0, 17, 12'h123, "latch", 1'b1);
      chg_rise = 0;

      // Reset mid-frame after the config bits were captured.
      ch1 = 12'h456;
      run_frame(1'b1, 1'b1, 1'b1, 0, 8, 12'h000, "pre_rst", 1'b0);
      rst = 1'b1;
      wait_clks(2);
      check_eq("mrst_miso", 32'(miso), 32'd0);
      check_eq("mrst_oe", 32'(miso_oe), 32'd0);
      check_eq("mrst_cfg_valid", 32'(cfg_valid), 32'd0);
      check_eq("mrst_cfg_bits", {29'd0, cfg_sgl, cfg_odd, cfg_msbf}, 32'd0);
      check_eq("mrst_conv_done", 32'(conv_done), 32'd0);
      check_eq("mrst_state", 32'(dbg.state), 32'(IDLE));
      cs = 1'b1;
      wait_clks(4);
      rst = 1'b0;
      wait_clks(4);
      ch0 = 12'h5A3; ch1 = 12'h0F0;
      run_frame(1'b1, 1'b0, 1'b1, 0, 17, 12'h5A3, "post_rst", 1'b1);
`ifdef RESPONDER_STATS_EN
      check_eq("end_frame_count", 32'(frame_count), 32'd1);
      check_eq("end_abort_count", 32'(abort_count), 32'd0);
`endif

      $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fails);
      $finish;
   end

endmodule

// File: doc/mcp3202_responder.md
Name: mcp3202_responder

Overview:
- SPI peripheral-side model of the MCP3202 12-bit ADC. Answers the existing SPI master with the MCP3202 frame: start, SGL/DIFF, ODD/SIGN and MSBF in; null bit and 12 data bits out.
- Serves as the self-checking bench partner for the controller and as an on-chip loopback target.
- Runs entirely in the system clock domain. Oversamples cs, spi_clk and mosi, which are asynchronous to clk.

Parameters:
- DATA_W, 12, conversion width; fixed at 12 for MCP3202 framing.
- SYNC_STAGES, 2, flops per synchroniser on cs/spi_clk/mosi; legal range 2..3.

Ports:
- clk  input  1  system clock; spi_clk must be at most clk/8.
- rst  input  1  synchronous, active-high reset.
- cs  input  1  chip select from master, active low.
- spi_clk  input  1  serial clock from master, idle low (mode 0,0).
- mosi  input  1  serial data from master.
- ch0_data  input  DATA_W  analog stand-in, channel 0.
- ch1_data  input  DATA_W  analog stand-in, channel 1.
- miso  output  1  serial data to master.
- miso_oe  output  1  high while responder drives miso; low means tri-state.
- cfg_valid  output  1  one-clk pulse when the MSBF bit is captured.
- cfg_sgl, cfg_odd, cfg_msbf  output  1 each  last captured config bits.
- conv_done  output  1  one-clk pulse after the final data bit of a complete frame.

Behaviour:
- Reset values: miso=0, miso_oe=0, cfg_valid=0, cfg_*=0, conv_done=0, state=IDLE, shift/counters=0. Reset mid-frame aborts the frame silently.
- Input path: each input passes SYNC_STAGES flops, then one compare flop. rise/fall/cs_fall/cs_rise are one-clk pulses. Latency from pin edge to action is SYNC_STAGES+1 clks.
- cs_rise in any state: go to IDLE, miso_oe=0, miso=0, no conv_done. This abort has priority over a coincident spi_clk edge.
- cs_fall: miso_oe=1, miso=0. The responder then drives 0 until the null bit.
- IDLE: on rise with cs low and mosi=1, go to CFG (start bit). Rises with mosi=0 are leading zeros and are ignored.
- CFG: three rises capture sgl, odd, msbf in order. On the third rise:
  - update cfg_*;
  - pulse cfg_valid;
  - latch the sample (see data select below);
  - go to NULLB.
- NULLB: next fall drives miso=0 (null bit), then go to MSB_DATA.
- MSB_DATA: each fall shifts out the sample MSB first, B11..B0, 12 falls. Leave MSB_DATA on the fall after B0 is presented:
  - if msbf=1, go to DONE with miso=0 and pulse conv_done;
  - if msbf=0, present B1 on that same fall and go to LSB_DATA.
- LSB_DATA: remaining falls present B2..B11 (B0 is shared with the MSB pass). The fall after B11 drives miso=0, pulses conv_done and goes to DONE.
- DONE: miso=0, miso_oe=1 until cs_rise. Extra clocks are ignored.
- Data select, latched once per frame on the MSBF rise so later ch*_data changes do not corrupt the frame:
  - sgl=1: odd=0 selects ch0, odd=1 selects ch1.
  - sgl=0, odd=0: ch0-ch1.
  - sgl=0, odd=1: ch1-ch0.
  - Differential results are computed DATA_W+1 bits wide and clamp to 0 when negative (pseudo-differential).
- Frame lengths measured from the start-bit rise: MSBF=1 needs 17 falls; MSBF=0 needs 28 falls.

Optional Feature:
- Macro RESPONDER_STATS_EN.
- Defined: adds frame_count[15:0] (increments on conv_done) and abort_count[15:0] (increments on cs_rise outside IDLE/DONE). Both counters are zeroed by rst and wrap at 0xFFFF->0.
- Undefined: these ports and counters do not exist; all other behaviour is identical.

Decomposition:
- mcp3202_pkg:
  - state enum {IDLE, CFG, NULLB, MSB_DATA, LSB_DATA, DONE};
  - localparams DATA_W=12, CFG_BITS=3, START_BIT=1'b1;
  - diff-clamp function.
- Sub-module spi_in_sync: SYNC_STAGES synchroniser plus edge detect for one input. Instantiated three times.

Test Plan:
- Single-ended, sgl=1 odd=0 msbf=1, ch0=12'hA5C -> cfg_valid once; miso after null bit is 1010_0101_1100; conv_done after the 17th fall.
- msbf=0, sgl=1 odd=1, ch1=12'h801 -> miso is 1000_0000_0001 then 000_0000_0001 (B1..B11); total 28 falls; conv_done once.
- Differential, sgl=0 odd=0, ch0=12'h100, ch1=12'h300 -> data 12'h000 (clamped). Same with odd=1 -> data 12'h200.
- Two leading mosi=0 rises before the start bit, ch0=12'hFFF -> frame still decodes; output is twelve 1s.
- cs raised after 6 data bits -> miso_oe=0 within SYNC_STAGES+1 clks; no conv_done. With RESPONDER_STATS_EN, abort_count=1 and frame_count=0.
- Change ch0 from 12'h123 to 12'hFFF mid-frame, and assert rst mid-frame on a second frame -> first frame returns 12'h123; after rst all outputs are at their reset values and the next frame completes normally.
